trig_pattern_gen: RTL and testbench
===================================

# trig_pattern_gen

Bench-side and self-test generator for the tag's packet-envelope trigger. Drives `trig_out` with the high/low envelope of a burst of 802.11b or 802.11n probe packets. Each high pulse spans the full tag-side window (info-got through mod/CRC end). The output feeds the tag controller's `trig` input on the iCE40 so tag timing can be exercised without an RF front end.

## Interface
- `CLK_PER_US`, 50: clk cycles per microsecond (50 MHz).
- `B_PKT_US`, 498: 11b envelope length in µs (2+144+320+32).
- `N_PKT_US`, 194: 11n envelope length in µs (2+64+128).
- `CNT_W`, 16: width of µs counter and gap input.

- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `abort`  in  1  level; terminates any burst.
- `mode`  in  2  2'b10 = 11b, 2'b01 = 11n; other values invalid.
- `pkt_count`  in  8  packets per burst; latched on accepted `start`.
- `gap_us`  in  CNT_W  low time between packets in µs; latched on accepted `start`.
- `trig_out`  out  1  envelope, high = packet present.
- `busy`  out  1  high from the cycle after an accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse at burst completion.
- `pkt_idx`  out  8  index of the current packet, 0-based.

## Operation
- Reset value of every output is 0. State is IDLE, both counters are 0, and latched fields are 0.
- States:
  - IDLE: waits for `start`.
  - BURST: `trig_out` = 1.
  - GAP: `trig_out` = 0.
  - FINISH: asserts `done` for one cycle, then returns to IDLE.
- IDLE + `start`:
  - With valid `mode` and `pkt_count` ≠ 0: latch `mode`, `pkt_count`, `gap_us`; go to BURST; `pkt_idx` = 0.
  - With invalid `mode` or `pkt_count` = 0: go to FINISH. `trig_out` never rises.
- BURST: leaves when the µs counter reaches the packet length selected by the latched mode.
  - If `pkt_idx` = `pkt_count`−1, go to FINISH.
  - Otherwise go to GAP.
- GAP: leaves when the µs counter reaches max(`gap_us`, 1), then goes to BURST and increments `pkt_idx`.
  - The minimum low time of 1 µs guarantees the receiver sees the falling edge and returns to idle.
- FINISH: drives `trig_out` low and holds `pkt_idx` at its final value. The next cycle is IDLE.
- `start` outside IDLE is ignored and does not queue.
- `abort` in any non-IDLE state goes to IDLE next cycle: `trig_out` = 0, `busy` = 0, no `done`.
  - `abort` takes priority over `start` in the same cycle.
- Each state entry clears both the divider (0..`CLK_PER_US`−1) and the µs counter. The µs counter saturates and never wraps.
- `reset` mid-burst: all outputs are 0 on the following cycle. There is no partial `done`.

## Timing
- Accepted `start` at edge t: `busy` and `trig_out` rise at t+1.
- `trig_out` high time is exactly `B_PKT_US`×`CLK_PER_US` cycles (24900 for 11b) or `N_PKT_US`×`CLK_PER_US` cycles (9700 for 11n).
- Low time between packets is exactly max(`gap_us`, 1)×`CLK_PER_US` cycles.
- `done` is high for exactly one cycle: the cycle after the last `trig_out` high cycle. `busy` falls together with `done`.
- Invalid request: `done` at t+1 and `busy` at t+1 for one cycle only.
- Outputs are registered with no combinational path from inputs.

## Configuration
- `TRIG_PATTERN_GEN_JITTER_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; reseeded on `reset`) advances once per GAP entry.
  - Its low 4 bits (0..15 µs) are added to each gap's terminal count.
- Undefined: gaps are exact, and no LFSR is present.

## Structure
- Shared package `loctag_pkg` holds:
  - the mode encodings (MODE_B = 2'b10, MODE_N = 2'b01);
  - the 11b/11n window constants (2/144/320/32 and 2/64/128 µs) and the derived packet lengths;
  - `CLK_PER_US`;
  - the state enum.
- One sub-module, `us_ticker`: a µs divider with synchronous clear that emits a one-cycle `tick`. It is reused by the tag controller.

## Test plan
- mode=10, pkt_count=1, gap_us=5, `start` → `trig_out` high for 24900 cycles from t+1; `done` pulse the next cycle; `pkt_idx`=0.
- mode=01, pkt_count=3, gap_us=10 → three 9700-cycle highs separated by 500-cycle lows; `pkt_idx` steps 0,1,2; a single `done`.
- mode=00 or pkt_count=0 → `done` and `busy` for one cycle at t+1; `trig_out` stays 0.
- gap_us=0, pkt_count=2, mode=01 → low gap of exactly 50 cycles.
- `abort` at cycle 3000 of the first 11b packet → `trig_out`=0 the next cycle, no `done`; then a fresh `start` is accepted; `start` pulsed mid-burst is ignored.
- `reset` asserted during GAP → all outputs 0 next cycle; with jitter macro on, two bursts give identical gap sequences.

Source files
------------

// File: rtl/loctag_pkg.sv
// Shared constants, mode encodings and FSM state type for the tag trigger path.
// Packet lengths are the full tag-side window: info-got through mod/CRC end.
package loctag_pkg;

    localparam int CLK_PER_US = 50;
    localparam int CNT_W      = 16;

    localparam logic [1:0] MODE_B = 2'b10;
    localparam logic [1:0] MODE_N = 2'b01;

    localparam int B_INFO_US     = 2;
    localparam int B_PREAMBLE_US = 144;
    localparam int B_MOD_US      = 320;
    localparam int B_CRC_US      = 32;
    localparam int B_PKT_US      = B_INFO_US + B_PREAMBLE_US + B_MOD_US + B_CRC_US;

    localparam int N_INFO_US     = 2;
    localparam int N_PREAMBLE_US = 64;
    localparam int N_MOD_US      = 128;
    localparam int N_PKT_US      = N_INFO_US + N_PREAMBLE_US + N_MOD_US;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    function automatic logic mode_valid(input logic [1:0] m);
        return (m == MODE_B) || (m == MODE_N);
    endfunction

endpackage

// File: rtl/us_ticker.sv
// Microsecond divider: counts 0..DIV-1 and pulses tick for one cycle on the last count.
// clr holds the divider at zero so the first tick lands a full microsecond after release.
module us_ticker #(
    parameter int DIV = loctag_pkg::CLK_PER_US
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign tick = (r_div == DIV_LAST) && !clr;

endmodule

// File: rtl/trig_pattern_gen.sv
// Packet-envelope trigger generator: bursts of 11b/11n-length highs separated by gaps.
// Define TRIG_PATTERN_GEN_JITTER_EN to add 0..15 us of LFSR jitter to every gap.
module trig_pattern_gen #(
    parameter int CLK_PER_US = loctag_pkg::CLK_PER_US,
    parameter int B_PKT_US   = loctag_pkg::B_PKT_US,
    parameter int N_PKT_US   = loctag_pkg::N_PKT_US,
    parameter int CNT_W      = loctag_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [7:0]       pkt_count,
    input  logic [CNT_W-1:0] gap_us,
    output logic             trig_out,
    output logic             busy,
    output logic             done,
    output logic [7:0]       pkt_idx
);
    import loctag_pkg::*;

    localparam logic [CNT_W:0] US_MAX = {1'b0, {CNT_W{1'b1}}};

    state_t           r_state;
    logic [1:0]       r_mode;
    logic [7:0]       r_pkt_count;
    logic [7:0]       r_pkt_idx;
    logic [CNT_W-1:0] r_gap;
    logic [CNT_W-1:0] r_us;
    logic             r_trig;
    logic             r_busy;
    logic             r_done;

    logic             w_tick;
    logic             w_tick_clr;
    logic [CNT_W:0]   w_us_inc;
    logic [CNT_W-1:0] w_us_sat;
    logic [CNT_W:0]   w_pkt_term;
    logic [CNT_W:0]   w_gap_base;
    logic [CNT_W:0]   w_gap_jit;
    logic [CNT_W:0]   w_gap_sum;
    logic [CNT_W:0]   w_gap_term;
    logic             w_burst_end;
    logic             w_last_pkt;
    logic             w_gap_entry;

    // Divider idles cleared; BURST/GAP exits land on a tick, so it wraps to 0 on every entry.
    assign w_tick_clr = (r_state == ST_IDLE) || (r_state == ST_FINISH);

    us_ticker #(
        .DIV (CLK_PER_US)
    ) u_ticker (
        .clk   (clk),
        .reset (reset),
        .clr   (w_tick_clr),
        .tick  (w_tick)
    );

    assign w_us_inc    = {1'b0, r_us} + 1'b1;
    assign w_us_sat    = (&r_us) ? r_us : r_us + 1'b1;
    assign w_pkt_term  = (r_mode == MODE_B) ? (CNT_W+1)'(B_PKT_US) : (CNT_W+1)'(N_PKT_US);
    assign w_gap_base  = (r_gap == '0) ? (CNT_W+1)'(1) : {1'b0, r_gap};
    assign w_gap_sum   = w_gap_base + w_gap_jit;
    assign w_gap_term  = (w_gap_sum > US_MAX) ? US_MAX : w_gap_sum;
    assign w_burst_end = (w_us_inc == w_pkt_term);
    assign w_last_pkt  = (r_pkt_idx == (r_pkt_count - 8'd1));
    assign w_gap_entry = (r_state == ST_BURST) && !abort && w_tick && w_burst_end && !w_last_pkt;

`ifdef TRIG_PATTERN_GEN_JITTER_EN
    logic [15:0] r_lfsr;

    // Fibonacci taps 16,14,13,11; the gap being entered sees the advanced value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else if (w_gap_entry) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_gap_jit = {{(CNT_W-3){1'b0}}, r_lfsr[3:0]};
`else
    assign w_gap_jit = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mode      <= '0;
            r_pkt_count <= '0;
            r_pkt_idx   <= '0;
            r_gap       <= '0;
            r_us        <= '0;
            r_trig      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state != ST_IDLE) && abort) begin
                r_state <= ST_IDLE;
                r_us    <= '0;
                r_trig  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_busy <= 1'b1;
                            r_us   <= '0;
                            if (mode_valid(mode) && (pkt_count != 8'd0)) begin
                                r_mode      <= mode;
                                r_pkt_count <= pkt_count;
                                r_gap       <= gap_us;
                                r_pkt_idx   <= 8'd0;
                                r_trig      <= 1'b1;
                                r_state     <= ST_BURST;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= ST_FINISH;
                            end
                        end
                    end
                    ST_BURST: begin
                        if (w_tick) begin
                            if (w_burst_end) begin
                                r_us   <= '0;
                                r_trig <= 1'b0;
                                if (w_last_pkt) begin
                                    r_done  <= 1'b1;
                                    r_state <= ST_FINISH;
                                end else begin
                                    r_state <= ST_GAP;
                                end
                            end else begin
                                r_us <= w_us_sat;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (w_tick) begin
                            if (w_us_inc == w_gap_term) begin
                                r_us      <= '0;
                                r_trig    <= 1'b1;
                                r_pkt_idx <= r_pkt_idx + 8'd1;
                                r_state   <= ST_BURST;
                            end else begin
                                r_us <= w_us_sat;
                            end
                        end
                    end
                    ST_FINISH: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign trig_out = r_trig;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pkt_idx  = r_pkt_idx;

endmodule

// File: tb/tb_trig_pattern_gen.sv
// Directed bench for trig_pattern_gen: envelope lengths, gaps, invalid requests, abort, reset.
module tb_trig_pattern_gen;

    localparam int CPU    = 50;
    localparam int B_HIGH = 498 * CPU;
    localparam int N_HIGH = 194 * CPU;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [7:0]  pkt_count;
    logic [15:0] gap_us;
    logic        trig_out;
    logic        busy;
    logic        done;
    logic [7:0]  pkt_idx;

    int n_total  = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int n        = 0;
    int d0       = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    trig_pattern_gen dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .pkt_count (pkt_count),
        .gap_us    (gap_us),
        .trig_out  (trig_out),
        .busy      (busy),
        .done      (done),
        .pkt_idx   (pkt_idx)
    );

    always #5 clk = ~clk;

    // Counts completed done cycles (value seen at the edge that ends the cycle).
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [1:0] m, input logic [7:0] c, input logic [15:0] g);
        mode      = m;
        pkt_count = c;
        gap_us    = g;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic count_while(input logic lvl, input int bound, output int cnt);
        cnt = 0;
        while (trig_out === lvl && cnt < bound) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    // Expected low time in cycles; the jitter build advances the model LFSR per gap.
    function automatic int exp_gap(input int g);
        int base;
        base = (g == 0) ? 1 : g;
`ifdef TRIG_PATTERN_GEN_JITTER_EN
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        base   = base + int'(m_lfsr[3:0]);
`endif
        return base * CPU;
    endfunction

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        mode      = 2'b00;
        pkt_count = 8'd0;
        gap_us    = 16'd0;
        repeat (3) step();
        chk("rst_trig", trig_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", pkt_idx, 0);
        reset = 1'b0;
        step();

        // 11b single packet
        do_start(2'b10, 8'd1, 16'd5);
        chk("b1_busy_rise", busy, 1);
        chk("b1_trig_rise", trig_out, 1);
        chk("b1_idx", pkt_idx, 0);
        count_while(1'b1, B_HIGH + 100, n);
        chk("b1_high_len", n, B_HIGH);
        chk("b1_done", done, 1);
        chk("b1_busy_fin", busy, 1);
        chk("b1_idx_fin", pkt_idx, 0);
        step();
        chk("b1_done_fall", done, 0);
        chk("b1_busy_fall", busy, 0);

        // 11n three packets, 10 us gaps
        d0 = done_cnt;
        do_start(2'b01, 8'd3, 16'd10);
        for (int p = 0; p < 3; p++) begin
            chk("n3_idx", pkt_idx, p);
            count_while(1'b1, N_HIGH + 100, n);
            chk("n3_high_len", n, N_HIGH);
            if (p < 2) begin
                chk("n3_no_done", done, 0);
                count_while(1'b0, 2000, n);
                chk("n3_gap_len", n, exp_gap(10));
            end
        end
        chk("n3_done", done, 1);
        chk("n3_idx_fin", pkt_idx, 2);
        step();
        step();
        chk("n3_done_count", done_cnt - d0, 1);

        // invalid mode, zero packet count
        d0 = done_cnt;
        do_start(2'b00, 8'd4, 16'd3);
        chk("inv_mode_done", done, 1);
        chk("inv_mode_busy", busy, 1);
        chk("inv_mode_trig", trig_out, 0);
        step();
        chk("inv_mode_done_fall", done, 0);
        chk("inv_mode_busy_fall", busy, 0);
        do_start(2'b10, 8'd0, 16'd3);
        chk("inv_cnt_done", done, 1);
        chk("inv_cnt_trig", trig_out, 0);
        step();
        chk("inv_cnt_busy_fall", busy, 0);
        step();
        chk("inv_done_count", done_cnt - d0, 2);

        // abort beats start in IDLE
        mode      = 2'b10;
        pkt_count = 8'd1;
        start     = 1'b1;
        abort     = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_pri_busy", busy, 0);
        chk("abort_pri_trig", trig_out, 0);

        // mid-burst start ignored, abort at cycle 3000 of an 11b packet
        d0 = done_cnt;
        do_start(2'b10, 8'd1, 16'd5);
        repeat (1000) step();
        do_start(2'b01, 8'd2, 16'd0);
        chk("midstart_trig", trig_out, 1);
        chk("midstart_idx", pkt_idx, 0);
        repeat (1998) step();
        chk("pre_abort_trig", trig_out, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_trig", trig_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (5) step();
        chk("abort_no_queue_busy", busy, 0);
        chk("abort_no_queue_trig", trig_out, 0);
        chk("abort_done_count", done_cnt - d0, 0);

        // fresh start, gap_us=0 gives a 1 us gap; reset during the second gap
        do_start(2'b01, 8'd3, 16'd0);
        chk("fresh_trig", trig_out, 1);
        chk("fresh_busy", busy, 1);
        count_while(1'b1, N_HIGH + 100, n);
        chk("g0_high_len", n, N_HIGH);
        count_while(1'b0, 2000, n);
        chk("g0_gap_len", n, exp_gap(0));
        chk("g0_idx", pkt_idx, 1);
        count_while(1'b1, N_HIGH + 100, n);
        chk("g0_high2_len", n, N_HIGH);
        repeat (20) step();
        chk("g0_in_gap_trig", trig_out, 0);
        chk("g0_in_gap_busy", busy, 1);
        d0 = done_cnt;
        reset = 1'b1;
        step();
        chk("mid_rst_trig", trig_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_idx", pkt_idx, 0);
        reset  = 1'b0;
        m_lfsr = 16'hACE1;
        repeat (3) step();
        chk("mid_rst_done_count", done_cnt - d0, 0);
        chk("mid_rst_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
